// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared constants for the image-window datapath.
//   PIX_W          bits per pixel
//   DEF_WIDTH      default pixels per image row
//   DEF_HEIGHT     default rows per frame
//   A1..A9         storage index of each window tap. The window is kept as a
//                  row-major array: A1 A2 A3 / A4 A5 A6 / A7 A8 A9.
//                  A5 is the centre pixel.
// ---------------------------------------------------------------------------
package img_pkg;

   localparam int PIX_W      = 8;
   localparam int DEF_WIDTH  = 850;
   localparam int DEF_HEIGHT = 850;

   localparam int A1 = 0;
   localparam int A2 = 1;
   localparam int A3 = 2;
   localparam int A4 = 3;
   localparam int A5 = 4;
   localparam int A6 = 5;
   localparam int A7 = 6;
   localparam int A8 = 7;
   localparam int A9 = 8;

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// Holds one image row of pixels, with DEPTH entries of W bits each.
// Reads are combinational. Writes are synchronous.
// When a read and a write use the same address in one cycle, the read returns
// the old contents. This lets the window generator pull a pixel out and push
// its replacement into the same column slot in a single cycle.
// The contents are never cleared.
// Ports:
//   clk    clock
//   we     write enable
//   addr   shared read/write address (column index)
//   wdata  data to write
//   rdata  current contents at addr
// ---------------------------------------------------------------------------
module line_buffer #(
   parameter  int DEPTH = 850,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   // Storage array. There is no reset, because stale row data is always
   // overwritten before it can reach a valid window.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// ---------------------------------------------------------------------------
// window_3x3_gen
// Streaming 3x3 neighbourhood generator.
// It takes raster-order pixels on a valid/ready handshake and presents each
// interior 3x3 window as taps a1..a9 (a5 is the centre). Two line buffers
// hold the previous two rows. Border windows are not emitted.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_pixel            raster-order input pixel
//   in_sof              marks the accepted pixel as frame position (0,0)
//   win_valid/out_ready window handshake toward the kernel
//   a1..a9              window taps
//   ctr_row/ctr_col     frame position of the centre tap a5
//   frame_done          one-cycle pulse after the last pixel of a frame
// ---------------------------------------------------------------------------
module window_3x3_gen
   import img_pkg::*;
#(
   parameter  int WIDTH  = DEF_WIDTH,
   parameter  int HEIGHT = DEF_HEIGHT,
   parameter  int PIX_W  = img_pkg::PIX_W,
   localparam int CW     = $clog2(WIDTH),
   localparam int RW     = $clog2(HEIGHT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_sof,
   output logic             win_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] a1,
   output logic [PIX_W-1:0] a2,
   output logic [PIX_W-1:0] a3,
   output logic [PIX_W-1:0] a4,
   output logic [PIX_W-1:0] a5,
   output logic [PIX_W-1:0] a6,
   output logic [PIX_W-1:0] a7,
   output logic [PIX_W-1:0] a8,
   output logic [PIX_W-1:0] a9,
   output logic [RW-1:0]    ctr_row,
   output logic [CW-1:0]    ctr_col,
   output logic             frame_done
);

   logic             accept;
   logic [RW-1:0]    row;
   logic [RW-1:0]    row_eff;
   logic [RW-1:0]    row_nxt;
   logic [CW-1:0]    col;
   logic [CW-1:0]    col_eff;
   logic [CW-1:0]    col_nxt;
   logic             last_col;
   logic             frame_end;
   logic             interior;
   logic [PIX_W-1:0] top;
   logic [PIX_W-1:0] mid;
   logic [PIX_W-1:0] win [9];

   // The block only stalls its input while a window is waiting to be
   // consumed. When the window is taken in the same cycle, a new pixel can
   // be accepted at once.
   assign in_ready = !win_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Work out the position of the incoming pixel.
   // A start-of-frame pixel is forced to (0,0), which resyncs the stream.
   // The same logic gives the counter values for the next pixel and flags
   // whether this pixel completes an interior window.
   always_comb begin
      row_eff   = in_sof ? '0 : row;
      col_eff   = in_sof ? '0 : col;
      last_col  = (col_eff == CW'(WIDTH - 1));
      frame_end = last_col && (row_eff == RW'(HEIGHT - 1));
      interior  = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
      row_nxt   = row_eff;
      col_nxt   = col_eff + CW'(1);
      if (last_col) begin
         col_nxt = '0;
         row_nxt = frame_end ? '0 : row_eff + RW'(1);
      end
   end

   // lb0 holds the row above the incoming pixel, and lb1 the row above that.
   // On each accept, the column slot moves down one buffer. The pixel read
   // out of lb0 is written into lb1, and the new pixel goes into lb0.
   line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_eff),
      .wdata (in_pixel),
      .rdata (mid)
   );

   line_buffer #(.DEPTH(WIDTH), .W(PIX_W)) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_eff),
      .wdata (mid),
      .rdata (top)
   );

   // Counters, window shift register and output handshake.
   // On each accept the window slides one column left, and the new right
   // column is filled from the two line buffers and the incoming pixel.
   // A window is flagged valid only when the incoming pixel is the
   // bottom-right corner of an interior neighbourhood. Pixels in the first
   // two columns of a row leave stale columns from the previous row in the
   // window, so those pixels clear win_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row        <= '0;
         col        <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         ctr_row    <= '0;
         ctr_col    <= '0;
         for (int k = 0; k < 9; k++) begin
            win[k] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            row        <= row_nxt;
            col        <= col_nxt;
            frame_done <= frame_end;
            win[A1]    <= win[A2];
            win[A2]    <= win[A3];
            win[A3]    <= top;
            win[A4]    <= win[A5];
            win[A5]    <= win[A6];
            win[A6]    <= mid;
            win[A7]    <= win[A8];
            win[A8]    <= win[A9];
            win[A9]    <= in_pixel;
            if (interior) begin
               win_valid <= 1'b1;
               ctr_row   <= row_eff - RW'(1);
               ctr_col   <= col_eff - CW'(1);
            end else begin
               win_valid <= 1'b0;
            end
         end else if (win_valid && out_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

   assign a1 = win[A1];
   assign a2 = win[A2];
   assign a3 = win[A3];
   assign a4 = win[A4];
   assign a5 = win[A5];
   assign a6 = win[A6];
   assign a7 = win[A7];
   assign a8 = win[A8];
   assign a9 = win[A9];

endmodule

// File: tb/tb_window_3x3_gen.sv
// ---------------------------------------------------------------------------
// tb_window_3x3_gen
// Directed testbench for window_3x3_gen on a 4x4 image.
// Unless a test says otherwise, the pixel at (r,c) has value base + 4*r + c.
// ---------------------------------------------------------------------------
module tb_window_3x3_gen;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_pixel;
   logic       in_sof;
   logic       win_valid;
   logic       out_ready;
   logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
   logic [1:0] ctr_row;
   logic [1:0] ctr_col;
   logic       frame_done;

   logic [7:0] taps  [9];
   logic [7:0] exp_w [9];
   logic [7:0] held  [9];
   int n_cmp;
   int n_fail;

   window_3x3_gen #(.WIDTH(4), .HEIGHT(4), .PIX_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
      .in_sof     (in_sof),
      .win_valid  (win_valid),
      .out_ready  (out_ready),
      .a1         (a1),
      .a2         (a2),
      .a3         (a3),
      .a4         (a4),
      .a5         (a5),
      .a6         (a6),
      .a7         (a7),
      .a8         (a8),
      .a9         (a9),
      .ctr_row    (ctr_row),
      .ctr_col    (ctr_col),
      .frame_done (frame_done)
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gather the taps into an array so window checks can loop over them.
   always_comb begin
      taps[0] = a1;
      taps[1] = a2;
      taps[2] = a3;
      taps[3] = a4;
      taps[4] = a5;
      taps[5] = a6;
      taps[6] = a7;
      taps[7] = a8;
      taps[8] = a9;
   end

   // Absolute time limit, in case a handshake never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Offer one pixel and wait, within a bounded number of cycles, until it
   // is accepted. The task returns 1 ns after the accepting edge.
   task automatic send(input logic [7:0] p, input logic sof);
      int budget;
      budget   = 0;
      in_valid = 1'b1;
      in_pixel = p;
      in_sof   = sof;
      while (!in_ready && budget < 20) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL send_timeout pixel %0d: in_ready got 0 want 1", p);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   // Hold reset for three cycles, then check every reset value.
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_pixel  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (win_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_win_valid got %0b want 0", win_valid);
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_frame_done got %0b want 0", frame_done);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready);
      end
      n_cmp++;
      if (ctr_row !== 2'd0 || ctr_col !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctr got (%0d,%0d) want (0,0)", ctr_row, ctr_col);
      end
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (taps[k] !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_tap a%0d got %0d want 0", k + 1, taps[k]);
         end
      end
      rst_n = 1'b1;
   endtask

   // Stream one full frame with out_ready held high. Exactly the four
   // interior windows must appear, each with the right taps and centre.
   task automatic test_stream();
      int r, c, nwin;
      nwin = 0;
      for (int idx = 0; idx < 16; idx++) begin
         r = idx / 4;
         c = idx % 4;
         send(8'(4 * r + c), idx == 0);
         n_cmp++;
         if (win_valid !== ((r >= 2) && (c >= 2))) begin
            n_fail++;
            $display("[TB] FAIL stream_win_valid px %0d got %0b want %0b", idx, win_valid, (r >= 2) && (c >= 2));
         end
         if (win_valid === 1'b1) nwin++;
         n_cmp++;
         if (frame_done !== (idx == 15)) begin
            n_fail++;
            $display("[TB] FAIL stream_frame_done px %0d got %0b want %0b", idx, frame_done, idx == 15);
         end
         if (r >= 2 && c >= 2) begin
            if (idx == 10) exp_w = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
            else if (idx == 15) exp_w = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
            else for (int k = 0; k < 9; k++) exp_w[k] = 8'(4 * (r - 2 + k / 3) + (c - 2 + k % 3));
            for (int k = 0; k < 9; k++) begin
               n_cmp++;
               if (taps[k] !== exp_w[k]) begin
                  n_fail++;
                  $display("[TB] FAIL stream_tap px %0d a%0d got %0d want %0d", idx, k + 1, taps[k], exp_w[k]);
               end
            end
            n_cmp++;
            if (ctr_row !== 2'(r - 1) || ctr_col !== 2'(c - 1)) begin
               n_fail++;
               $display("[TB] FAIL stream_ctr px %0d got (%0d,%0d) want (%0d,%0d)", idx, ctr_row, ctr_col, r - 1, c - 1);
            end
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL stream_idle got valid=%0b done=%0b want 0/0", win_valid, frame_done);
      end
      n_cmp++;
      if (nwin !== 4) begin
         n_fail++;
         $display("[TB] FAIL stream_window_count got %0d want 4", nwin);
      end
   endtask

   // Hold off the kernel while a window is pending. The input must stall
   // and the window must stay frozen until out_ready is raised again.
   task automatic test_stall();
      for (int idx = 0; idx < 11; idx++) send(8'(idx), idx == 0);
      n_cmp++;
      if (win_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL stall_first_valid got %0b want 1", win_valid);
      end
      held      = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pixel  = 8'd11;
      #1;
      for (int cyc = 0; cyc < 5; cyc++) begin
         n_cmp++;
         if (in_ready !== 1'b0 || win_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_handshake cyc %0d got ready=%0b valid=%0b want 0/1", cyc, in_ready, win_valid);
         end
         n_cmp++;
         if (ctr_row !== 2'd1 || ctr_col !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL stall_ctr cyc %0d got (%0d,%0d) want (1,1)", cyc, ctr_row, ctr_col);
         end
         for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (taps[k] !== held[k]) begin
               n_fail++;
               $display("[TB] FAIL stall_tap cyc %0d a%0d got %0d want %0d", cyc, k + 1, taps[k], held[k]);
            end
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_w    = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      n_cmp++;
      if (win_valid !== 1'b1 || ctr_row !== 2'd1 || ctr_col !== 2'd2) begin
         n_fail++;
         $display("[TB] FAIL stall_release got valid=%0b ctr=(%0d,%0d) want 1 (1,2)", win_valid, ctr_row, ctr_col);
      end
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (taps[k] !== exp_w[k]) begin
            n_fail++;
            $display("[TB] FAIL stall_release_tap a%0d got %0d want %0d", k + 1, taps[k], exp_w[k]);
         end
      end
   endtask

   // Continue the frame from test_stall into its last row. The first two
   // pixels of the row must not produce a window. Pixel (3,2) must then
   // produce a window holding fresh data.
   task automatic test_row_wrap();
      send(8'd12, 1'b0);
      n_cmp++;
      if (win_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL wrap_px12_valid got %0b want 0", win_valid);
      end
      send(8'd13, 1'b0);
      n_cmp++;
      if (win_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL wrap_px13_valid got %0b want 0", win_valid);
      end
      send(8'd14, 1'b0);
      exp_w = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
      n_cmp++;
      if (win_valid !== 1'b1 || ctr_row !== 2'd2 || ctr_col !== 2'd1) begin
         n_fail++;
         $display("[TB] FAIL wrap_px14 got valid=%0b ctr=(%0d,%0d) want 1 (2,1)", win_valid, ctr_row, ctr_col);
      end
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (taps[k] !== exp_w[k]) begin
            n_fail++;
            $display("[TB] FAIL wrap_tap a%0d got %0d want %0d", k + 1, taps[k], exp_w[k]);
         end
      end
      send(8'd15, 1'b0);
      n_cmp++;
      if (frame_done !== 1'b1 || a9 !== 8'd15) begin
         n_fail++;
         $display("[TB] FAIL wrap_px15 got done=%0b a9=%0d want 1 15", frame_done, a9);
      end
      @(posedge clk);
      #1;
   endtask

   // Check that frame_done is a single-cycle pulse. Then send a second frame
   // (base 100) without in_sof; the counters must have wrapped to (0,0).
   task automatic test_frame_done();
      for (int idx = 0; idx < 16; idx++) begin
         send(8'(idx), idx == 0);
         n_cmp++;
         if (frame_done !== (idx == 15)) begin
            n_fail++;
            $display("[TB] FAIL fd_pulse px %0d got %0b want %0b", idx, frame_done, idx == 15);
         end
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL fd_pulse_width got %0b want 0", frame_done);
      end
      for (int idx = 0; idx < 11; idx++) send(8'(100 + idx), 1'b0);
      exp_w = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
      n_cmp++;
      if (win_valid !== 1'b1 || ctr_row !== 2'd1 || ctr_col !== 2'd1) begin
         n_fail++;
         $display("[TB] FAIL fd_frame2 got valid=%0b ctr=(%0d,%0d) want 1 (1,1)", win_valid, ctr_row, ctr_col);
      end
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (taps[k] !== exp_w[k]) begin
            n_fail++;
            $display("[TB] FAIL fd_frame2_tap a%0d got %0d want %0d", k + 1, taps[k], exp_w[k]);
         end
      end
      for (int idx = 11; idx < 16; idx++) send(8'(100 + idx), 1'b0);
      @(posedge clk);
      #1;
   endtask

   // Check resync behaviour. First, reset part-way through a frame: the next
   // frame (base 20, no in_sof) must produce no window before its 11th
   // pixel. Second, assert in_sof on the 6th pixel of a frame: counting
   // restarts at that pixel (base 60).
   task automatic test_resync();
      for (int idx = 0; idx < 7; idx++) send(8'(idx), idx == 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_cmp++;
      if (win_valid !== 1'b0 || a5 !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL rs_reset got valid=%0b a5=%0d want 0 0", win_valid, a5);
      end
      for (int idx = 0; idx < 11; idx++) begin
         send(8'(20 + idx), 1'b0);
         n_cmp++;
         if (win_valid !== (idx == 10)) begin
            n_fail++;
            $display("[TB] FAIL rs_after_reset px %0d valid got %0b want %0b", idx, win_valid, idx == 10);
         end
      end
      exp_w = '{20, 21, 22, 24, 25, 26, 28, 29, 30};
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (taps[k] !== exp_w[k]) begin
            n_fail++;
            $display("[TB] FAIL rs_reset_tap a%0d got %0d want %0d", k + 1, taps[k], exp_w[k]);
         end
      end
      for (int idx = 0; idx < 5; idx++) send(8'(idx), idx == 0);
      for (int k = 0; k < 11; k++) begin
         send(8'(60 + k), k == 0);
         n_cmp++;
         if (win_valid !== (k == 10)) begin
            n_fail++;
            $display("[TB] FAIL rs_sof px %0d valid got %0b want %0b", k, win_valid, k == 10);
         end
      end
      exp_w = '{60, 61, 62, 64, 65, 66, 68, 69, 70};
      n_cmp++;
      if (ctr_row !== 2'd1 || ctr_col !== 2'd1) begin
         n_fail++;
         $display("[TB] FAIL rs_sof_ctr got (%0d,%0d) want (1,1)", ctr_row, ctr_col);
      end
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (taps[k] !== exp_w[k]) begin
            n_fail++;
            $display("[TB] FAIL rs_sof_tap a%0d got %0d want %0d", k + 1, taps[k], exp_w[k]);
         end
      end
   endtask

   // Run every scenario in order, then print the summary line.
   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_stream();
      test_stall();
      test_row_wrap();
      test_frame_done();
      test_resync();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
